// File: rtl/aes_sbox_pkg.sv
// Shared constants and GF arithmetic for the AES S-box engine. The tower-field basis
// change is derived at elaboration from the field definitions rather than hand-typed.
package aes_sbox_pkg;

  localparam logic [8:0] AES_POLY     = 9'h11B;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic       MODE_FWD     = 1'b0;
  localparam logic       MODE_INV     = 1'b1;
  localparam logic [4:0] GF16_POLY    = 5'h13;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF16_POLY[3:0] : 4'h0);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return gf16_mul(a, a);
  endfunction

  // a^14 == a^-1 in GF(16); maps 0 to 0 as required
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf16_sq(a);
    a4 = gf16_sq(a2);
    a8 = gf16_sq(a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  // Composite element {h,l} = h*y + l with y^2 = y + lam
  function automatic logic [7:0] gf256t_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] lam);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, lam) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // GF(2) linear map; column i of m is the image of bit i
  function automatic logic [7:0] map_apply(input logic [63:0] m, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = r ^ m[8*i +: 8];
    end
    return r;
  endfunction

  // Smallest lam with y^2 + y + lam irreducible over GF(16)
  function automatic logic [3:0] find_lambda();
    logic [3:0] lam;
    logic       found;
    logic       hit;
    lam   = '0;
    found = 1'b0;
    for (int l = 1; l < 16; l++) begin
      hit = 1'b0;
      for (int t = 0; t < 16; t++) begin
        if ((gf16_sq(4'(t)) ^ 4'(t)) == 4'(l)) hit = 1'b1;
      end
      if (!hit && !found) begin
        lam   = 4'(l);
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  // Polynomial basis -> tower basis: x^i maps to beta^i, beta a root of AES_POLY
  function automatic logic [63:0] find_iso(input logic [3:0] lam);
    logic [7:0]  beta;
    logic [7:0]  pw;
    logic [7:0]  acc;
    logic        found;
    logic [63:0] m;
    beta  = '0;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      if (!found) begin
        pw  = 8'h01;
        acc = '0;
        for (int k = 0; k < 9; k++) begin
          if (AES_POLY[k]) acc = acc ^ pw;
          pw = gf256t_mul(pw, 8'(c), lam);
        end
        if (acc == 8'h00) begin
          beta  = 8'(c);
          found = 1'b1;
        end
      end
    end
    m  = '0;
    pw = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = pw;
      pw = gf256t_mul(pw, beta, lam);
    end
    return m;
  endfunction

  function automatic logic [63:0] invert_map(input logic [63:0] m);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      for (int v = 0; v < 256; v++) begin
        if (map_apply(m, 8'(v)) == (8'h01 << j)) r[8*j +: 8] = 8'(v);
      end
    end
    return r;
  endfunction

  localparam logic [3:0]  TOWER_LAMBDA = find_lambda();
  localparam logic [63:0] ISO_MAP      = find_iso(TOWER_LAMBDA);
  localparam logic [63:0] ISO_INV_MAP  = invert_map(ISO_MAP);

endpackage

// File: rtl/aes_sbox_gf256_inv.sv
// Combinational GF(2^8) multiplicative inverse (poly 0x11B) through GF((2^4)^2).
module gf256_inv
  import aes_sbox_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] t;
  logic [3:0] h;
  logic [3:0] l;
  logic [3:0] d;
  logic [3:0] di;

  assign t  = map_apply(ISO_MAP, a);
  assign h  = t[7:4];
  assign l  = t[3:0];
  // Norm of h*y + l; its GF(16) inverse yields the conjugate-based inverse
  assign d  = gf16_mul(gf16_sq(h), TOWER_LAMBDA) ^ gf16_mul(h, l) ^ gf16_sq(l);
  assign di = gf16_inv(d);
  assign y  = map_apply(ISO_INV_MAP, {gf16_mul(h, di), gf16_mul(h ^ l, di)});

endmodule

// File: rtl/aes_sbox_core.sv
// Byte-wide AES SubBytes / InvSubBytes engine sharing one GF(2^8) inverter, 1-cycle latency.
module aes_sbox_core
  import aes_sbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ INV_AFFINE_C;
  endfunction

  logic       mode;
  logic       capture;
  logic [7:0] pre_p0;
  logic [7:0] inv_p0;
  logic [7:0] sub_p0;
  logic [7:0] result_p1;
  logic       vld_p1;
  logic       unused_uio;

  assign mode       = uio_in[0];
  assign capture    = ena && uio_in[1];
  assign unused_uio = ^uio_in[7:2];

  assign pre_p0 = (mode == MODE_INV) ? affine_inv(ui_in) : ui_in;

  gf256_inv u_inv (
    .a (pre_p0),
    .y (inv_p0)
  );

  assign sub_p0 = (mode == MODE_FWD) ? affine_fwd(inv_p0) : inv_p0;

  // p0 -> p1: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= 8'h00;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (capture) result_p1 <= sub_p0;
    end
  end

  assign uo_out  = result_p1;
  assign uio_out = {vld_p1, 7'b0};
  assign uio_oe  = 8'h80;

endmodule

// File: tb/tb_aes_sbox_core.sv
// Randomized and directed bench for aes_sbox_core against a brute-force GF(2^8) reference.
module tb_aes_sbox_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  aes_sbox_core dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];
  logic [7:0] exp_out;
  logic       exp_vld;
  logic [7:0] fwd_in  [4];
  logic [7:0] fwd_out [4];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int v = 1; v < 256; v++) begin
      if (gmul(a, 8'(v)) == 8'h01) r = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [7:0] rot(input logic [7:0] b, input int n);
    int x;
    x = ((int'(b) << n) | (int'(b) >> (8 - n))) & 255;
    return 8'(x);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic s, input logic m,
                       input logic [7:0] d);
    rst    = r;
    ena    = e;
    ui_in  = d;
    uio_in = {6'($urandom), s, m};
    @(posedge clk);
    #1;
    if (r) begin
      exp_out = 8'h00;
      exp_vld = 1'b0;
    end else if (e && s) begin
      exp_out = m ? inv_m[d] : sbox_m[d];
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    chk("uo_out", uo_out, exp_out);
    chk("uio_out", uio_out, {exp_vld, 7'b0});
    chk("uio_oe", uio_oe, 8'h80);
  endtask

  initial begin
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = ginv(8'(x));
      sbox_m[x] = b ^ rot(b, 1) ^ rot(b, 2) ^ rot(b, 3) ^ rot(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_m[sbox_m[x]] = 8'(x);
    fwd_in  = '{8'h00, 8'h01, 8'h53, 8'hFF};
    fwd_out = '{8'h63, 8'h7C, 8'hED, 8'h16};
    exp_out = 8'h00;
    exp_vld = 1'b0;

    cycle(1, 1, 1, 0, 8'h53);
    cycle(1, 1, 1, 1, 8'h7C);
    chk("reset_out", uo_out, 8'h00);

    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 0, fwd_in[i]);
      chk("fwd_vec", uo_out, fwd_out[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 1, fwd_out[i]);
      chk("inv_vec", uo_out, fwd_in[i]);
      cycle(0, 1, 1, 0, fwd_in[i]);
      chk("toggle_fwd", uo_out, fwd_out[i]);
    end

    for (int x = 0; x < 256; x++) cycle(0, 1, 1, 0, 8'(x));
    for (int x = 0; x < 256; x++) begin
      cycle(0, 1, 1, 1, sbox_m[x]);
      chk("inv_roundtrip", uo_out, 8'(x));
    end

    cycle(0, 1, 1, 0, 8'h01);
    cycle(0, 1, 0, 0, 8'h53);
    chk("hold_nostrobe", uo_out, 8'h7C);
    cycle(0, 0, 1, 1, 8'hED);
    chk("hold_ena0", uo_out, 8'h7C);
    cycle(0, 0, 0, 0, 8'h00);

    cycle(0, 1, 1, 0, 8'hFF);
    cycle(1, 1, 1, 0, 8'h53);
    chk("rst_mid", uo_out, 8'h00);
    cycle(0, 1, 1, 0, 8'h53);
    chk("resume", uo_out, 8'hED);

    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
